// File: rtl/lcd_spi_stream.sv
// lcd_spi_stream: FIFO-buffered MSB-first SPI word serialiser for ST7789-class panels
// Ports: CLK, RESET (async, active high); ENABLE gates transmission and backlight;
//   HW_RESET_REQ reruns the panel reset sequence; S_DATA/S_LEN/S_DC/S_VALID/S_READY push
//   {DC, LEN, DATA} words; FIFO_LEVEL, INIT_DONE, BUSY report status;
//   LCD_BLK/LCD_RST/LCD_DC/LCD_SDA/LCD_SCK drive the panel (SCK idles high, mode 3).
// Define LCD_SPI_STATS_EN to add the WORD_COUNT and STARVE_COUNT outputs.
module lcd_spi_stream #(
  parameter int DATA_W          = 24,
  parameter int FIFO_DEPTH      = 16,
  parameter int SCK_DIV         = 2,
  parameter int RST_LOW_CYCLES  = 1_000,
  parameter int RST_WAIT_CYCLES = 12_000_000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          HW_RESET_REQ,
  input  logic [DATA_W-1:0]             S_DATA,
  input  logic [1:0]                    S_LEN,
  input  logic                          S_DC,
  input  logic                          S_VALID,
  output logic                          S_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          INIT_DONE,
  output logic                          BUSY,
  output logic                          LCD_BLK,
  output logic                          LCD_RST,
  output logic                          LCD_DC,
  output logic                          LCD_SDA,
  output logic                          LCD_SCK
`ifdef LCD_SPI_STATS_EN
  ,
  output logic [31:0]                   WORD_COUNT,
  output logic [31:0]                   STARVE_COUNT
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 3;
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, LOAD, SHIFT} state_t;
  state_t state, nxt;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] cnt;
  logic [23:0] aligned;
  logic [22:0] sr;
  logic [4:0] bits, head_bits;
  logic [1:0] head_len;
  logic half, pend, live, blk, sck, sda, dc;
  logic empty, full, push, pop, last, word_end;
  assign FIFO_LEVEL = wr_ptr - rd_ptr;
  assign empty      = FIFO_LEVEL == '0;
  assign full       = FIFO_LEVEL == (AW+1)'(FIFO_DEPTH);
  assign S_READY    = live & ~full;
  assign push       = S_VALID & S_READY;
  assign pop        = state == LOAD;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_len   = head[DATA_W+1:DATA_W];
  // words are right-aligned in the FIFO; the shifter wants them MSB-first at bit 23
  assign aligned    = head_len == 2'd0 ? {head[7:0], 16'h0} :
                      head_len == 2'd1 ? {head[15:0], 8'h0} : head[23:0];
  assign head_bits  = head_len == 2'd0 ? 5'd8 : head_len == 2'd1 ? 5'd16 : 5'd24;
  assign last       = cnt == 32'(SCK_DIV - 1);
  assign word_end   = state == SHIFT && half && last && bits == 5'd1;
  assign INIT_DONE  = state inside {IDLE, LOAD, SHIFT};
  assign BUSY       = ~empty | (state inside {LOAD, SHIFT});
  assign LCD_RST    = state != RST_LOW;
  assign LCD_BLK    = blk;
  assign LCD_SCK    = sck;
  assign LCD_SDA    = sda;
  assign LCD_DC     = dc;

  always_ff @(posedge CLK)
    if (push) mem[wr_ptr[AW-1:0]] <= {S_DC, S_LEN, S_DATA};

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= RST_LOW;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      RST_LOW:  if (cnt == 32'(RST_LOW_CYCLES - 1)) nxt = RST_WAIT;
      RST_WAIT: if (cnt == 32'(RST_WAIT_CYCLES - 1)) nxt = IDLE;
      IDLE:     nxt = pend ? RST_LOW : (!empty && ENABLE) ? LOAD : IDLE;
      LOAD:     nxt = SHIFT;
      SHIFT:    if (word_end) nxt = (!empty && ENABLE && !pend) ? LOAD : IDLE;
      default:  nxt = RST_LOW;
    endcase
  end

  // cnt times both the reset phases and each SCK half-period; it restarts on every state change
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      cnt  <= '0;
      sr   <= '0;
      bits <= '0;
      half <= 1'b0;
      pend <= 1'b0;
      live <= 1'b0;
      blk  <= 1'b0;
      sck  <= 1'b1;
      sda  <= 1'b0;
      dc   <= 1'b0;
    end else begin
      live <= 1'b1;
      blk  <= INIT_DONE & ENABLE;
      pend <= HW_RESET_REQ | (pend & (state != IDLE));
      cnt  <= (nxt != state || (state == SHIFT && last)) ? '0 : cnt + 1'b1;
      if (state == LOAD) begin
        dc   <= head[EW-1];
        sr   <= aligned[22:0];
        bits <= head_bits;
        sck  <= 1'b0;
        sda  <= aligned[23];
        half <= 1'b0;
      end else if (state == SHIFT && last) begin
        if (!half) begin
          sck  <= 1'b1;
          half <= 1'b1;
        end else if (bits != 5'd1) begin
          sck  <= 1'b0;
          sda  <= sr[22];
          sr   <= {sr[21:0], 1'b0};
          bits <= bits - 1'b1;
          half <= 1'b0;
        end
      end
    end

`ifdef LCD_SPI_STATS_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      WORD_COUNT   <= '0;
      STARVE_COUNT <= '0;
    end else begin
      WORD_COUNT   <= WORD_COUNT + 32'(word_end);
      STARVE_COUNT <= STARVE_COUNT + 32'(state == IDLE && ENABLE && empty);
    end
`endif
endmodule

// File: tb/tb_lcd_spi_stream.sv
// tb_lcd_spi_stream: directed self-checking bench for lcd_spi_stream
module tb_lcd_spi_stream;
  logic CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b1, HW_RESET_REQ = 1'b0;
  logic S_DC = 1'b0, S_VALID = 1'b0;
  logic [23:0] S_DATA = '0;
  logic [1:0] S_LEN = '0;
  logic S_READY, INIT_DONE, BUSY, LCD_BLK, LCD_RST, LCD_DC, LCD_SDA, LCD_SCK;
  logic [4:0] FIFO_LEVEL;
  int tests = 0, fails = 0, ncap = 0, nfall = 0;
  logic hist [4096];

  always #5 CLK = ~CLK;

  lcd_spi_stream #(
    .DATA_W(24), .FIFO_DEPTH(16), .SCK_DIV(2), .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .HW_RESET_REQ(HW_RESET_REQ),
    .S_DATA(S_DATA), .S_LEN(S_LEN), .S_DC(S_DC), .S_VALID(S_VALID), .S_READY(S_READY),
    .FIFO_LEVEL(FIFO_LEVEL), .INIT_DONE(INIT_DONE), .BUSY(BUSY), .LCD_BLK(LCD_BLK),
    .LCD_RST(LCD_RST), .LCD_DC(LCD_DC), .LCD_SDA(LCD_SDA), .LCD_SCK(LCD_SCK)
  );

  always @(posedge LCD_SCK) begin
    hist[ncap % 4096] = LCD_SDA;
    ncap++;
  end
  always @(negedge LCD_SCK) nfall++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [23:0] d, input logic [1:0] l, input logic c);
    S_DATA = d;
    S_LEN = l;
    S_DC = c;
    S_VALID = 1'b1;
    tick;
    S_VALID = 1'b0;
  endtask

  function automatic logic [31:0] bits_at(input int s, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], hist[(s + i) % 4096]};
    return v;
  endfunction

  initial begin
    int b0, f0, k, mx, run;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_pins", {LCD_RST, LCD_SCK, LCD_SDA, LCD_DC, LCD_BLK}, 5'b01000);
    check("reset_status", {INIT_DONE, BUSY, S_READY}, 3'b000);
    check("reset_level", FIFO_LEVEL, 0);
    @(negedge CLK);
    RESET = 1'b0;
    f0 = nfall;
    repeat (3) tick;
    check("ready_after_release", S_READY, 1);
    check("rst_low_3", LCD_RST, 0);
    tick;
    check("rst_high_4", LCD_RST, 1);
    repeat (7) tick;
    check("init_not_11", INIT_DONE, 0);
    tick;
    check("init_at_12", INIT_DONE, 1);
    check("blk_not_12", LCD_BLK, 0);
    tick;
    check("blk_at_13", LCD_BLK, 1);
    check("sck_idle_high", {LCD_SCK, 32'(nfall - f0)}, {1'b1, 32'd0});

    b0 = ncap;
    push(24'h00002A, 2'd0, 1'b0);
    check("byte_level", FIFO_LEVEL, 1);
    check("byte_busy", BUSY, 1);
    tick;
    check("byte_load_sck", LCD_SCK, 1);
    tick;
    check("byte_first_fall", {LCD_SCK, LCD_DC, LCD_SDA}, 3'b000);
    repeat (31) tick;
    check("byte_busy_end", BUSY, 1);
    tick;
    check("byte_idle", BUSY, 0);
    check("byte_edges", ncap - b0, 8);
    check("byte_value", bits_at(b0, 8), 32'h2A);

    b0 = ncap;
    push(24'h00F800, 2'd1, 1'b1);
    push(24'h00001F, 2'd1, 1'b1);
    k = 0;
    run = 0;
    mx = 0;
    while (BUSY && k < 400) begin
      tick;
      k++;
      if (BUSY) begin
        run = LCD_SCK ? run + 1 : 0;
        if (run > mx) mx = run;
      end
    end
    check("dual_cycles", k, 130);
    check("dual_gap", mx, 3);
    check("dual_edges", ncap - b0, 32);
    check("dual_value", bits_at(b0, 32), 32'hF800001F);
    check("dual_dc", LCD_DC, 1);

    ENABLE = 1'b0;
    for (int i = 0; i < 15; i++) push(24'(8'h10 + i), 2'd0, 1'b1);
    check("fill15_ready", S_READY, 1);
    check("fill15_level", FIFO_LEVEL, 15);
    push(24'h00001F, 2'd0, 1'b1);
    check("fill16_ready", S_READY, 0);
    check("fill16_level", FIFO_LEVEL, 16);
    push(24'h000020, 2'd0, 1'b1);
    check("fill17_level", FIFO_LEVEL, 16);
    check("disabled_pins", {LCD_BLK, LCD_SCK}, 2'b01);
    b0 = ncap;
    ENABLE = 1'b1;
    for (k = 0; k < 2000 && BUSY; k++) tick;
    check("drain_level", FIFO_LEVEL, 0);
    check("drain_edges", ncap - b0, 128);
    for (int i = 0; i < 16; i++) check($sformatf("drain_word%0d", i), bits_at(b0 + 8 * i, 8), 32'(8'h10 + i));

    b0 = ncap;
    f0 = nfall;
    push(24'hA5C33C, 2'd2, 1'b0);
    push(24'h00005A, 2'd0, 1'b1);
    for (k = 0; k < 200 && nfall - f0 < 5; k++) tick;
    HW_RESET_REQ = 1'b1;
    tick;
    HW_RESET_REQ = 1'b0;
    for (k = 0; k < 200 && LCD_RST; k++) tick;
    check("hwrst_word_edges", ncap - b0, 24);
    check("hwrst_word_value", bits_at(b0, 24), 32'hA5C33C);
    check("hwrst_init_low", INIT_DONE, 0);
    check("hwrst_fifo_kept", FIFO_LEVEL, 1);
    for (k = 0; k < 50 && !LCD_RST; k++) tick;
    check("hwrst_low_cycles", k, 4);
    for (k = 0; k < 50 && !INIT_DONE; k++) tick;
    check("hwrst_wait_cycles", k, 8);
    check("hwrst_held", ncap - b0, 24);
    for (k = 0; k < 200 && BUSY; k++) tick;
    check("hwrst_resume_edges", ncap - b0, 32);
    check("hwrst_resume_value", bits_at(b0 + 24, 8), 32'h5A);
    check("hwrst_resume_dc", LCD_DC, 1);

    f0 = nfall;
    for (int i = 0; i < 3; i++) push(24'h0000FF, 2'd0, 1'b1);
    for (k = 0; k < 100 && nfall - f0 < 2; k++) tick;
    #3;
    check("pre_reset_pins", {LCD_SCK, LCD_SDA, LCD_BLK}, 3'b011);
    RESET = 1'b1;
    #1;
    check("async_reset_pins", {LCD_SCK, LCD_SDA, LCD_RST, LCD_BLK}, 4'b1000);
    check("async_reset_level", FIFO_LEVEL, 0);
    @(negedge CLK);
    RESET = 1'b0;
    tick;
    check("post_reset_state", {FIFO_LEVEL, BUSY, INIT_DONE, LCD_RST}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_spi_stream.md
# lcd_spi_stream

Parametrised serial output engine for ST7789-class SPI panels (no chip-select, 4-wire: SCK/SDA/DC/RST plus backlight). It buffers command and pixel words of 8, 16 or 24 bits in an internal FIFO and serialises them MSB-first with a programmable SCK rate. It also owns the panel hardware-reset sequence and backlight gating. It sits between a frame/text renderer and the panel pins, replacing the fixed-format driver with a width-, depth- and rate-generic core.

## Interface
- DATA_W, 24: maximum word width in bits; must be ≥ 24.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥ 2.
- SCK_DIV, 2: CLK cycles per SCK half-period; ≥ 1.
- RST_LOW_CYCLES, 1_000: cycles LCD_RST is held low.
- RST_WAIT_CYCLES, 12_000_000: cycles after LCD_RST release before INIT_DONE.

Ports:
- CLK  in  1  system clock; sole clock.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  transmit enable; also gates backlight.
- HW_RESET_REQ  in  1  single-cycle request to rerun the panel reset sequence.
- S_DATA  in  DATA_W  word, right-aligned.
- S_LEN  in  2  0 = 8 bit, 1 = 16 bit, 2 or 3 = 24 bit.
- S_DC  in  1  0 = command, 1 = data.
- S_VALID  in  1  word valid.
- S_READY  out  1  FIFO not full.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- INIT_DONE  out  1  panel reset sequence complete.
- BUSY  out  1  FIFO non-empty or word in flight.
- LCD_BLK, LCD_RST, LCD_DC, LCD_SDA, LCD_SCK  out  1 each  panel pins.

## Operation
- Reset values: LCD_RST=0, LCD_SCK=1, LCD_SDA=0, LCD_DC=0, LCD_BLK=0, INIT_DONE=0, BUSY=0, S_READY=0, FIFO_LEVEL=0. After release, S_READY = !full.
- Push occurs when S_VALID & S_READY. Each entry is {DC, LEN, DATA}. Pushes are accepted in any state, including during the reset sequence.
- FSM states:
  - RST_LOW: LCD_RST=0 for RST_LOW_CYCLES → RST_WAIT.
  - RST_WAIT: LCD_RST=1 for RST_WAIT_CYCLES → IDLE, with INIT_DONE=1.
  - IDLE: if a reset request is pending → RST_LOW, with INIT_DONE=0. Else if FIFO non-empty & ENABLE → LOAD.
  - LOAD (1 cycle): pop the FIFO, drive LCD_DC=entry DC, load the shift register with the word MSB-aligned, set the bit count to 8/16/24 → SHIFT.
  - SHIFT: for each bit, LCD_SCK=0 for SCK_DIV cycles with LCD_SDA=current bit (changes on the falling edge), then LCD_SCK=1 for SCK_DIV cycles (panel samples on the rising edge). After the last high half → LOAD if FIFO non-empty & ENABLE & no pending request, else IDLE.
- Idle levels: LCD_SCK idles high (SPI mode 3). LCD_SDA and LCD_DC hold their last values outside SHIFT.
- HW_RESET_REQ sets a sticky pending flag in any state. The flag is serviced only in IDLE or at end of word, so an in-flight word always completes. FIFO contents survive.
- ENABLE deasserted mid-word: the word completes, then the FSM holds in IDLE.
- Full FIFO with simultaneous pop: S_READY stays 0 in that cycle (no bypass).
- LCD_BLK = registered (INIT_DONE & ENABLE).
- BUSY = FIFO non-empty | state ∈ {LOAD, SHIFT}.
- Asynchronous RESET mid-operation: all outputs go to reset values immediately, the FIFO is flushed, and the FSM enters RST_LOW on release.

## Timing
- Bit period = 2·SCK_DIV cycles. Word of N bits = 1 (LOAD) + 2·SCK_DIV·N cycles.
- Back-to-back words have exactly one LOAD cycle with SCK high between them.
- Push to first falling SCK edge from an empty IDLE: 3 cycles (write, IDLE→LOAD, LOAD→SHIFT).
- FIFO_LEVEL and S_READY update one cycle after a push or pop.
- INIT_DONE rises RST_LOW_CYCLES + RST_WAIT_CYCLES cycles after RESET release. LCD_BLK follows one cycle later.

## Configuration
- LCD_SPI_STATS_EN defined: adds two outputs.
  - WORD_COUNT (out, 32): words completed; wraps at 2^32.
  - STARVE_COUNT (out, 32): cycles in IDLE with INIT_DONE & ENABLE & FIFO empty; wraps.
  - Both counters reset to 0 on RESET.
- LCD_SPI_STATS_EN undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- RST_LOW_CYCLES=4, RST_WAIT_CYCLES=8, ENABLE=1, release RESET → LCD_RST low for 4 cycles then high; INIT_DONE at cycle 12; LCD_BLK at cycle 13; SCK stays 1 throughout.
- SCK_DIV=2, push 0x2A with S_LEN=0, S_DC=0 → LCD_DC=0; 8 rising edges sampling 0,0,1,0,1,0,1,0; 32 shift cycles; BUSY falls after the last high half.
- Push 0xF800 then 0x001F, both S_LEN=1, S_DC=1 → 32 rising edges total, one-cycle SCK-high gap between words, LCD_DC=1, sampled words match.
- ENABLE=0, push 17 words with FIFO_DEPTH=16 → S_READY=0 after the 16th, FIFO_LEVEL=16, 17th not accepted. Then ENABLE=1 → 16 words emitted in order, FIFO_LEVEL=0.
- HW_RESET_REQ pulse during the 5th bit of a 24-bit word → word completes in full, LCD_RST low for RST_LOW_CYCLES, queued words resume only after INIT_DONE.
- Assert RESET mid-SHIFT → LCD_SCK=1, LCD_SDA=0, LCD_RST=0, LCD_BLK=0 in the same cycle; FIFO_LEVEL=0 afterwards.
